// File: rtl/csr_arb_pkg.sv
// CSR bus arbiter shared definitions: bus widths, requester limits, FSM states.
package csr_arb_pkg;

    localparam int CSR_AW  = 5;
    localparam int CSR_DW  = 8;
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/csr_rr_pick.sv
// Round-robin picker: first eligible requester after 'last', wrapping modulo N.
import csr_arb_pkg::*;

module csr_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2:0] cand;
    logic       hit;

    // Walk candidates from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        hit   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            // last <= N-1 and k <= N-1, so one subtraction keeps cand below N
            cand = {1'b0, last} + 3'd1 + 3'(k);
            if (cand >= 3'(N)) begin
                cand = cand - 3'(N);
            end
            hit = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (cand == 3'(j)) begin
                    hit = elig[j];
                end
            end
            if (hit) begin
                valid = 1'b1;
                idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/csr_arbiter.sv
// CSR bus arbiter: one access at a time, round-robin with per-requester bus lock.
// Optional write-protect window enabled by defining CSR_ARB_WPROT_EN.
//
// state  | meaning
// IDLE   | pick a requester, capture its address/data/write onto the bus
// ACCESS | bus driven for one cycle, read data captured, ack prepared
// DONE   | ack/err visible for this cycle only, inputs ignored
import csr_arb_pkg::*;

module csr_arbiter #(
    parameter int                NUM_REQ   = 2,
    parameter logic [CSR_AW-1:0] PROT_BASE = 5'h00,
    parameter logic [CSR_AW-1:0] PROT_LAST = 5'h07
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ-1:0]        we_in,
    input  logic [CSR_AW*NUM_REQ-1:0] a_in,
    input  logic [CSR_DW*NUM_REQ-1:0] di_in,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic [CSR_DW-1:0]         rdata,
    output logic [CSR_AW-1:0]         csr_a,
    output logic [CSR_DW-1:0]         csr_di,
    output logic                      csr_we,
    input  logic [CSR_DW-1:0]         csr_do
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic               lvld_q, lvld_d;
    logic [IDX_W-1:0]   lown_q, lown_d;
    logic               blk_q, blk_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               err_q, err_d;
    logic [CSR_DW-1:0]  rdata_q, rdata_d;
    logic [CSR_AW-1:0]  csr_a_q, csr_a_d;
    logic [CSR_DW-1:0]  csr_di_q, csr_di_d;
    logic               csr_we_q, csr_we_d;

    logic [NUM_REQ-1:0] own_oh;
    logic               owner_lock;
    logic [NUM_REQ-1:0] elig;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [CSR_AW-1:0]  sel_a;
    logic [CSR_DW-1:0]  sel_di;
    logic               sel_we;
    logic               sel_lock;
    logic               sel_blk;

    // Lock owner decode: owner keeps exclusivity only while it holds lock.
    always_comb begin
        own_oh     = '0;
        owner_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (lown_q == IDX_W'(i)) begin
                own_oh[i]  = 1'b1;
                owner_lock = lvld_q & lock[i];
            end
        end
    end

    assign elig = owner_lock ? (req & own_oh) : req;

    csr_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .elig  (elig),
        .last  (last_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // Mux the picked requester's access fields.
    always_comb begin
        sel_a    = '0;
        sel_di   = '0;
        sel_we   = 1'b0;
        sel_lock = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                sel_a    = a_in[CSR_AW*i +: CSR_AW];
                sel_di   = di_in[CSR_DW*i +: CSR_DW];
                sel_we   = we_in[i];
                sel_lock = lock[i];
            end
        end
    end

`ifdef CSR_ARB_WPROT_EN
    // Offset compare handles the window without a constant-bound comparison.
    assign sel_blk = sel_we && (pick_idx != '0) &&
                     ((sel_a - PROT_BASE) <= (PROT_LAST - PROT_BASE));
`else
    assign sel_blk = 1'b0;
`endif

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        lvld_d   = lvld_q;
        lown_d   = lown_q;
        blk_d    = blk_q;
        ack_d    = '0;
        err_d    = 1'b0;
        rdata_d  = rdata_q;
        csr_a_d  = '0;
        csr_di_d = '0;
        csr_we_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (lvld_q && !owner_lock) begin
                    lvld_d = 1'b0;
                end
                if (pick_vld) begin
                    gnt_d    = pick_idx;
                    last_d   = pick_idx;
                    csr_a_d  = sel_a;
                    csr_di_d = sel_di;
                    csr_we_d = sel_we & ~sel_blk;
                    blk_d    = sel_blk;
                    lvld_d   = sel_lock;
                    lown_d   = pick_idx;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (!blk_q) begin
                    rdata_d = csr_do;
                end
                for (int i = 0; i < NUM_REQ; i++) begin
                    ack_d[i] = (gnt_q == IDX_W'(i));
                end
                err_d   = blk_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            lvld_q   <= 1'b0;
            lown_q   <= '0;
            blk_q    <= 1'b0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            csr_a_q  <= '0;
            csr_di_q <= '0;
            csr_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            lvld_q   <= lvld_d;
            lown_q   <= lown_d;
            blk_q    <= blk_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            csr_a_q  <= csr_a_d;
            csr_di_q <= csr_di_d;
            csr_we_q <= csr_we_d;
        end
    end

    assign ack    = ack_q;
    assign err    = err_q;
    assign rdata  = rdata_q;
    assign csr_a  = csr_a_q;
    assign csr_di = csr_di_q;
    assign csr_we = csr_we_q;

endmodule
